// File: rtl/lut_neuron_loader.sv
// Runtime-programmable LUT neuron.
// A loader streams a truth table over a valid/ready config port into
// distributed RAM; once the table is complete the block serves registered
// lookups with the same address/data shape as a generated neuron ROM.
module lut_neuron_loader #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int LOAD_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [LOAD_W-1:0]   cfg_data,
    output logic                cfg_done,
    output logic                loaded,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
);

    localparam int DEPTH = 1 << IN_BITS;
    localparam int EPB   = LOAD_W / OUT_BITS;   // table entries per config beat
    localparam int BEATS = DEPTH / EPB;         // beats per full table
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_READY
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    beat_cnt;
    logic                cfg_fire;
    logic                last_fire;
    logic                in_fire;
    logic [OUT_BITS-1:0] mem [DEPTH];

    assign cfg_fire  = cfg_valid && cfg_ready;
    assign last_fire = cfg_fire && (beat_cnt == LAST_BEAT);
    assign in_fire   = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: cfg_start overrides everything and (re)enters LOAD.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // and infers a latch.
        state_nxt = state;
        if (cfg_start) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_LOAD:  if (last_fire) state_nxt = S_READY;
                default: state_nxt = state;
            endcase
        end
    end

    // Output decode: handshakes are masked on a cfg_start cycle.
    always_comb begin
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        loaded    = 1'b0;
        case (state)
            S_LOAD:  cfg_ready = !cfg_start;
            S_READY: begin
                loaded   = 1'b1;
                in_ready = !cfg_start;
            end
            default: ;
        endcase
    end

    // Beat counter and the one-cycle completion pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= last_fire;
            if (cfg_start) begin
                beat_cnt <= '0;
            end else if (cfg_fire) begin
                beat_cnt <= last_fire ? '0 : beat_cnt + 1'b1;
            end
        end
    end

    // Table write: slice k of beat b lands in entry b*EPB+k.
    always_ff @(posedge clk) begin
        // NOTE: the table RAM has no reset; its contents only matter after a
        // full load, and leaving it unreset keeps it mappable to LUT RAM.
        if (cfg_fire) begin
            for (int k = 0; k < EPB; k++) begin
                mem[IN_BITS'(int'(beat_cnt) * EPB + k)] <= cfg_data[k*OUT_BITS +: OUT_BITS];
            end
        end
    end

    // Registered lookup: one-cycle latency, data holds when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_fire;
            if (in_fire) begin
                out_data <= mem[in_data];
            end
        end
    end

endmodule
